alu_share_arb: RTL and testbench

- Time-shares one combinational 32-bit ALU between two requesters, e.g. the EX stage (port 0) and a secondary engine such as an address/iterative unit (port 1).
- Accepts one operation at a time over valid/ready, drives the ALU from registered operands, captures result and Zero, and presents a held response tagged with the requester id.
- Arbitration is round-robin; a completed-operation counter is kept for debug.

---
 rtl/alu_share_arb.sv | 121 ++++++++++++
 tb/tb_alu_share_arb.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// Round-robin time-sharing of one external combinational ALU between two requesters.
// One operation in flight; the response is held until the consumer takes it.
module alu_share_arb #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 4,
    parameter int unsigned CNTW  = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_ctrl,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_zero,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_res,
    output logic             rsp_zero,

    output logic [CNTW-1:0]  op_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state;
    logic       last_grant;
    logic       id_q;

    logic       can_accept;
    logic       grant0;
    logic       grant1;
    logic       accept;
    logic       rsp_done;

    // A slot opens either when idle or when the held response leaves this cycle.
    always_comb begin
        can_accept = (state == IDLE) || ((state == RESP) && rsp_ready);
        grant0     = req0_valid && (!req1_valid || last_grant);
        grant1     = req1_valid && (!req0_valid || !last_grant);
        req0_ready = can_accept && grant0;
        req1_ready = can_accept && grant1;
        accept     = req0_ready || req1_ready;
        rsp_done   = (state == RESP) && rsp_ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            id_q       <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_res    <= '0;
            rsp_zero   <= 1'b0;
            op_count   <= '0;
        end else begin
            if (rsp_done) begin
                op_count  <= op_count + 1'b1;
                rsp_valid <= 1'b0;
            end

            if (accept) begin
                if (req1_ready) begin
                    alu_a    <= req1_a;
                    alu_b    <= req1_b;
                    alu_ctrl <= req1_op;
                end else begin
                    alu_a    <= req0_a;
                    alu_b    <= req0_b;
                    alu_ctrl <= req0_op;
                end
                id_q       <= req1_ready;
                last_grant <= req1_ready;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_res   <= alu_res;
                    rsp_zero  <= alu_zero;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_done) begin
                        state <= accept ? EXEC : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a small behavioural ALU on the shared port.
module tb_alu_share_arb;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned OPW   = 4;
    localparam int unsigned CNTW  = 4;

    localparam logic [OPW-1:0] OP_AND = 4'd0;
    localparam logic [OPW-1:0] OP_OR  = 4'd1;
    localparam logic [OPW-1:0] OP_ADD = 4'd2;
    localparam logic [OPW-1:0] OP_SUB = 4'd6;
    localparam logic [OPW-1:0] OP_SLT = 4'd7;
    localparam logic [OPW-1:0] OP_SRA = 4'd8;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0_valid, req0_ready;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic [OPW-1:0]   req0_op;
    logic             req1_valid, req1_ready;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic [OPW-1:0]   req1_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_res;
    logic [OPW-1:0]   alu_ctrl;
    logic             alu_zero;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_zero;
    logic [WIDTH-1:0] rsp_res;
    logic [CNTW-1:0]  op_count;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    alu_share_arb #(.WIDTH(WIDTH), .OPW(OPW), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_res(alu_res), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_res(rsp_res), .rsp_zero(rsp_zero),
        .op_count(op_count)
    );

    // SRA shifts SrcB right arithmetically by SrcA[4:0].
    always_comb begin
        case (alu_ctrl)
            OP_AND:  alu_res = alu_a & alu_b;
            OP_OR:   alu_res = alu_a | alu_b;
            OP_ADD:  alu_res = alu_a + alu_b;
            OP_SUB:  alu_res = alu_a - alu_b;
            OP_SLT:  alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
            OP_SRA:  alu_res = $unsigned($signed(alu_b) >>> alu_a[4:0]);
            default: alu_res = '0;
        endcase
        alu_zero = (alu_res == '0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        req0_valid = 0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_op = '0;
        rsp_ready = 0;
        #2;
        do_reset();

        // Reset state
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_ctrl", alu_ctrl, 0);
        chk("rst_rsp_res", rsp_res, 0);
        chk("rst_ready0_idle", req0_ready, 0);

        // req0 ADD 5+7
        req0_valid = 1; req0_a = 5; req0_b = 7; req0_op = OP_ADD;
        #1;
        chk("t1_ready0", req0_ready, 1);
        chk("t1_ready1", req1_ready, 0);
        tick();
        req0_valid = 0;
        chk("t1_alu_a", alu_a, 5);
        chk("t1_alu_b", alu_b, 7);
        chk("t1_alu_ctrl", alu_ctrl, OP_ADD);
        chk("t1_exec_valid", rsp_valid, 0);
        tick();
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_id", rsp_id, 0);
        chk("t1_rsp_res", rsp_res, 12);
        chk("t1_rsp_zero", rsp_zero, 0);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("t1_count", op_count, 1);
        chk("t1_valid_drop", rsp_valid, 0);

        // req1 SUB 9-9 with a stalled consumer; req0 waits meanwhile
        req1_valid = 1; req1_a = 9; req1_b = 9; req1_op = OP_SUB;
        #1;
        chk("t2_ready1", req1_ready, 1);
        tick();
        req1_valid = 0;
        tick();
        req0_valid = 1; req0_a = 1; req0_b = 1; req0_op = OP_ADD;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_stall_valid", rsp_valid, 1);
            chk("t2_stall_id", rsp_id, 1);
            chk("t2_stall_res", rsp_res, 0);
            chk("t2_stall_zero", rsp_zero, 1);
            chk("t2_stall_ready0", req0_ready, 0);
            tick();
        end
        rsp_ready = 1;
        #1;
        chk("t2_release_ready0", req0_ready, 1);
        tick();
        req0_valid = 0;
        chk("t2_count", op_count, 2);
        chk("t2_valid_drop", rsp_valid, 0);
        chk("t2_alu_a", alu_a, 1);
        tick();
        chk("t2_rsp2_id", rsp_id, 0);
        chk("t2_rsp2_res", rsp_res, 2);
        tick();
        rsp_ready = 0;
        chk("t2_count2", op_count, 3);

        // Both requesters busy, consumer always ready: grants alternate from port 0
        do_reset();
        rsp_ready = 1;
        req0_valid = 1; req0_a = 1; req0_b = 1; req0_op = OP_ADD;
        req1_valid = 1; req1_a = 4; req1_b = 1; req1_op = OP_OR;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_grant0", req0_ready, (i % 2 == 0) ? 1 : 0);
            chk("t3_grant1", req1_ready, (i % 2 == 1) ? 1 : 0);
            if (i > 0) begin
                chk("t3_rsp_valid", rsp_valid, 1);
                chk("t3_rsp_id", rsp_id, (i % 2 == 0) ? 1 : 0);
                chk("t3_rsp_res", rsp_res, (i % 2 == 0) ? 5 : 2);
            end
            tick();
            chk("t3_exec_ready0", req0_ready, 0);
            chk("t3_exec_ready1", req1_ready, 0);
            chk("t3_exec_valid", rsp_valid, 0);
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        chk("t3_last_id", rsp_id, 1);
        chk("t3_last_res", rsp_res, 5);
        tick();
        rsp_ready = 0;
        chk("t3_count", op_count, 4);

        // Reset while req0 ADD 3+4 is executing
        do_reset();
        req0_valid = 1; req0_a = 3; req0_b = 4; req0_op = OP_ADD;
        tick();
        req0_valid = 0;
        reset = 1;
        #1;
        chk("t4_rst_valid", rsp_valid, 0);
        chk("t4_rst_alu_a", alu_a, 0);
        tick();
        reset = 0;
        tick();
        chk("t4_after_valid", rsp_valid, 0);
        chk("t4_after_count", op_count, 0);
        req0_valid = 1; req1_valid = 1;
        req1_a = 10; req1_b = 3; req1_op = OP_SUB;
        #1;
        chk("t4_tie_ready0", req0_ready, 1);
        chk("t4_tie_ready1", req1_ready, 0);
        tick();
        req0_valid = 0; req1_valid = 0;
        tick();
        chk("t4_rsp_id", rsp_id, 0);
        chk("t4_rsp_res", rsp_res, 7);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("t4_count", op_count, 1);

        // Counter wraps after 2^CNTW+3 operations
        do_reset();
        req1_a = 2; req1_b = 3; req1_op = OP_AND;
        for (int i = 0; i < 19; i++) begin
            req1_valid = 1;
            tick();
            req1_valid = 0;
            tick();
            rsp_ready = 1;
            tick();
            rsp_ready = 0;
            if (i == 15) chk("t5_wrap_zero", op_count, 0);
        end
        chk("t5_wrap_count", op_count, 3);
        chk("t5_and_res", rsp_res, 2);

        // SRA through the shared ALU, control code passed unmodified
        req0_valid = 1; req0_a = 4; req0_b = 32'h8000_0000; req0_op = OP_SRA;
        tick();
        req0_valid = 0;
        chk("t6_alu_ctrl", alu_ctrl, OP_SRA);
        tick();
        chk("t6_rsp_res", rsp_res, 32'hF800_0000);
        chk("t6_rsp_zero", rsp_zero, 0);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("t6_count", op_count, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
